// File: rtl/buzzer_pattern_gen.sv
// Beep-pattern generator: N tone bursts of on_ms separated by off_ms gaps.
// Optional BUZZER_GAIN_SEL_EN adds a latched amplifier gain select input.
module buzzer_pattern_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int HP_W   = 17,
    parameter int MS_W   = 10,
    parameter int REP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [HP_W-1:0]  half_period,
    input  logic [MS_W-1:0]  on_ms,
    input  logic [MS_W-1:0]  off_ms,
    input  logic [REP_W-1:0] repeats,
`ifdef BUZZER_GAIN_SEL_EN
    input  logic             gain_sel,
`endif
    output logic             busy,
    output logic             done,
    output logic             audio_out,
    output logic             amp_gain,
    output logic             amp_shdn
);

    localparam int MS_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int MS_CW  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [MS_CW-1:0] MS_TC = MS_CW'(MS_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    state_t state, state_n;

    logic [HP_W-1:0]  hp_l;
    logic [MS_W-1:0]  on_l;
    logic [MS_W-1:0]  off_l;
    logic [REP_W-1:0] rep_l;

    logic [MS_CW-1:0] ms_cnt;
    logic [MS_W-1:0]  ph_cnt;
    logic [HP_W-1:0]  tone_cnt;
    logic [REP_W-1:0] beep_cnt;

    logic accept;
    logic ms_tc;
    logic on_end;
    logic off_end;
    logic last;
    logic done_n;
    logic phase_new;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done_n  = 1'b0;
        ms_tc   = (ms_cnt == MS_TC);
        on_end  = ms_tc && (ph_cnt == on_l - MS_W'(1));
        off_end = ms_tc && (ph_cnt == off_l - MS_W'(1));
        last    = (beep_cnt == rep_l);
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_n = ON;
                    end
                end
                ON: begin
                    if (on_end) begin
                        if (last) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = OFF;
                        end
                    end
                end
                OFF: begin
                    if (off_end) state_n = ON;
                end
                default: state_n = IDLE;
            endcase
        end
        phase_new = (state_n != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Zero durations and half-periods are promoted to 1 at latch time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_l  <= '0;
            on_l  <= '0;
            off_l <= '0;
            rep_l <= '0;
        end else if (accept) begin
            hp_l  <= (half_period == '0) ? HP_W'(1) : half_period;
            on_l  <= (on_ms == '0) ? MS_W'(1) : on_ms;
            off_l <= (off_ms == '0) ? MS_W'(1) : off_ms;
            rep_l <= repeats;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
            ph_cnt <= '0;
        end else if (phase_new || state_n == IDLE) begin
            ms_cnt <= '0;
            ph_cnt <= '0;
        end else if (ms_tc) begin
            ms_cnt <= '0;
            ph_cnt <= ph_cnt + MS_W'(1);
        end else begin
            ms_cnt <= ms_cnt + MS_CW'(1);
        end
    end

    // Tone restarts low on every ON entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt  <= '0;
            audio_out <= 1'b0;
        end else if (state_n == ON && !phase_new) begin
            if (tone_cnt == hp_l - HP_W'(1)) begin
                tone_cnt  <= '0;
                audio_out <= ~audio_out;
            end else begin
                tone_cnt <= tone_cnt + HP_W'(1);
            end
        end else begin
            tone_cnt  <= '0;
            audio_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
        end else if (accept) begin
            beep_cnt <= '0;
        end else if (state == ON && state_n == OFF) begin
            beep_cnt <= beep_cnt + REP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            amp_shdn <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= (state_n != IDLE);
            amp_shdn <= (state_n != IDLE);
            done     <= done_n;
        end
    end

`ifdef BUZZER_GAIN_SEL_EN
    logic gain_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_l   <= 1'b0;
            amp_gain <= 1'b1;
        end else begin
            if (accept) gain_l <= gain_sel;
            if (state_n == IDLE) amp_gain <= 1'b1;
            else if (accept)     amp_gain <= gain_sel;
            else                 amp_gain <= gain_l;
        end
    end
`else
    assign amp_gain = 1'b1;
`endif

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Directed scoreboard bench for buzzer_pattern_gen at CLK_HZ=100_000.
// Define BUZZER_GAIN_SEL_EN to exercise the gain select input.
module tb_buzzer_pattern_gen;

    localparam int CLK_HZ = 100_000;
    localparam int HP_W   = 17;
    localparam int MS_W   = 10;
    localparam int REP_W  = 4;
`ifdef BUZZER_GAIN_SEL_EN
    localparam bit GAIN_EN = 1'b1;
`else
    localparam bit GAIN_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [HP_W-1:0]  half_period;
    logic [MS_W-1:0]  on_ms;
    logic [MS_W-1:0]  off_ms;
    logic [REP_W-1:0] repeats;
    logic             gain_sel;
    logic             busy;
    logic             done;
    logic             audio_out;
    logic             amp_gain;
    logic             amp_shdn;

    buzzer_pattern_gen #(
        .CLK_HZ(CLK_HZ),
        .HP_W  (HP_W),
        .MS_W  (MS_W),
        .REP_W (REP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .half_period(half_period),
        .on_ms      (on_ms),
        .off_ms     (off_ms),
        .repeats    (repeats),
`ifdef BUZZER_GAIN_SEL_EN
        .gain_sel   (gain_sel),
`endif
        .busy       (busy),
        .done       (done),
        .audio_out  (audio_out),
        .amp_gain   (amp_gain),
        .amp_shdn   (amp_shdn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic g;

    // {busy, amp_shdn, audio_out, done, amp_gain}
    logic [4:0] exp_q[$];

    function automatic logic exp_gain(input logic sel);
        return GAIN_EN ? sel : 1'b1;
    endfunction

    function automatic void push_on(input int hp, input int n, input logic gn);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, 1'b1, ((i / hp) % 2) == 1, 1'b0, gn});
        end
    endfunction

    function automatic void push_off(input int n, input logic gn);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, gn});
    endfunction

    function automatic void push_idle(input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 1'b0, 1'b0, (i == 0) && d, 1'b1});
        end
    endfunction

    task automatic check_one(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %b", tag,
                   {busy, amp_shdn, audio_out, done, amp_gain});
        end else begin
            e = exp_q.pop_front();
            o = {busy, amp_shdn, audio_out, done, amp_gain};
            assert (o === e) passes++;
            else begin
                fails++;
                $error("FAIL %s: observed %b expected %b (busy,shdn,audio,done,gain)",
                       tag, o, e);
            end
        end
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check_one(tag);
        end
    endtask

    task automatic cfg(input int hp, input int on, input int off, input int rep,
                       input logic gs);
        half_period = HP_W'(hp);
        on_ms       = MS_W'(on);
        off_ms      = MS_W'(off);
        repeats     = REP_W'(rep);
        gain_sel    = gs;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg(0, 0, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        push_idle(1, 1'b0);
        check_one("reset");
        rst_n = 1'b1;
        push_idle(2, 1'b0);
        step("idle", 2);

        // single 2 ms beep, half period 5
        cfg(5, 2, 7, 0, 1'b0);
        g = exp_gain(1'b0);
        start = 1'b1;
        push_on(5, 200, g);
        push_idle(3, 1'b1);
        step("single", 203);

        // three 1 ms bursts with 1 ms gaps
        cfg(3, 1, 1, 2, 1'b1);
        g = exp_gain(1'b1);
        start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            push_on(3, 100, g);
            if (b < 2) push_off(100, g);
        end
        push_idle(2, 1'b1);
        step("burst3", 502);

        // abort midway into the second burst
        start = 1'b1;
        push_on(3, 100, g);
        push_off(100, g);
        push_on(3, 50, g);
        step("pre_abort", 250);
        abort = 1'b1;
        push_idle(3, 1'b0);
        step("abort", 3);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        push_idle(2, 1'b0);
        step("abort_wins", 2);

        // start while busy with different fields is ignored
        cfg(4, 1, 1, 0, 1'b0);
        g = exp_gain(1'b0);
        start = 1'b1;
        push_on(4, 100, g);
        push_idle(1, 1'b1);
        step("busy_a", 30);
        cfg(7, 3, 2, 3, 1'b1);
        start = 1'b1;
        step("busy_b", 71);

        // start in the done cycle; zero fields act as 1
        cfg(0, 0, 0, 0, 1'b1);
        g = exp_gain(1'b1);
        start = 1'b1;
        push_on(1, 100, g);
        push_idle(2, 1'b1);
        step("zero_fields", 102);

        // asynchronous reset in the middle of ON
        cfg(0, 0, 0, 1, 1'b0);
        g = exp_gain(1'b0);
        start = 1'b1;
        push_on(1, 60, g);
        step("pre_rst", 60);
        rst_n = 1'b0;
        #1;
        push_idle(1, 1'b0);
        check_one("rst_async");
        @(negedge clk);
        push_idle(1, 1'b0);
        check_one("rst_hold");
        rst_n = 1'b1;
        push_idle(3, 1'b0);
        step("post_rst", 3);

        checks++;
        assert (exp_q.size() == 0) passes++;
        else begin
            fails++;
            $error("FAIL drain: observed %0d leftover expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/buzzer_pattern_gen.md
BUZZER_PATTERN_GEN -- requirements
Module: buzzer_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter HP_W, default 17, width of the tone half-period field.
REQ-003 SHALL have parameter MS_W, default 10, width of the on/off duration fields, in ms.
REQ-004 SHALL have parameter REP_W, default 4, width of the repeat-count field.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request a pattern; sampled only while busy=0.
REQ-009 abort  input  1  terminate any pattern immediately.
REQ-010 half_period  input  HP_W  tone half-period in clk cycles; latched on start.
REQ-011 on_ms, off_ms  input  MS_W each  beep and gap durations in ms; latched on start.
REQ-012 repeats  input  REP_W  extra beeps; total beeps = repeats+1; latched on start.
REQ-013 gain_sel  input  1  amplifier gain select; present only with BUZZER_GAIN_SEL_EN.
REQ-014 busy  output  1  high from accepted start until return to IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 audio_out, amp_gain, amp_shdn  output  1 each  square wave, amp gain (1 = 12 dB), amp enable (1 = on).

Function
REQ-017 SHALL implement FSM states IDLE, ON, OFF.
REQ-018 IDLE with start=1 and abort=0: latch all config fields, clear the beep counter, enter ON next cycle.
REQ-019 start while busy=1 SHALL be ignored; the latched config SHALL NOT change.
REQ-020 A zero on_ms, off_ms or half_period SHALL be treated as 1.
REQ-021 Ms prescaler: terminal count CLK_HZ/1000-1; cleared on every state entry, so a phase of N ms lasts exactly N*CLK_HZ/1000 cycles.
REQ-022 ON: audio_out SHALL be 0 in the first ON cycle and toggle every half_period cycles; the tone counter SHALL restart on each ON entry.
REQ-023 End of ON, beeps done = repeats+1: go to IDLE and pulse done in the first IDLE cycle; no trailing OFF.
REQ-024 End of ON otherwise: increment the beep counter and enter OFF.
REQ-025 End of OFF SHALL enter ON.
REQ-026 audio_out SHALL be 0 in IDLE and OFF.
REQ-027 busy SHALL be 1 in ON and OFF, 0 in IDLE; amp_shdn SHALL equal busy.
REQ-028 abort=1 in any state: IDLE next cycle with audio_out=0 and no done pulse.
REQ-029 abort with start in the same IDLE cycle: abort wins; stay IDLE.
REQ-030 start in the cycle done=1 SHALL be accepted, since busy=0 then.
REQ-031 All outputs SHALL be registered; counters SHALL NOT wrap inside a phase.

Reset
REQ-032 While rst_n=0: state IDLE; busy=0, done=0, audio_out=0, amp_shdn=0; amp_gain=1; all counters and latched config cleared.
REQ-033 Reset asserted mid-pattern SHALL abort immediately and asynchronously, with no done pulse.

Configuration
REQ-034 Macro BUZZER_GAIN_SEL_EN defined: gain_sel port exists and is latched on start; amp_gain = latched value while busy, 1 in IDLE.
REQ-035 Macro BUZZER_GAIN_SEL_EN undefined: no gain_sel port; amp_gain is constant 1.

Verification (CLK_HZ=100_000, so 1 ms = 100 cycles)
REQ-036 start with half_period=5, on_ms=2, repeats=0 -> audio toggles every 5 cycles for 200 cycles; done pulses once; busy high for exactly 200 cycles.
REQ-037 start with on_ms=1, off_ms=1, repeats=2 -> ON/OFF/ON/OFF/ON of 100 cycles each; 3 bursts; done after 500 busy cycles.
REQ-038 abort 50 cycles into the second burst -> IDLE next cycle; audio_out=0, amp_shdn=0, no done.
REQ-039 start during busy with changed fields -> ignored; timing matches the original fields.
REQ-040 on_ms=0, half_period=0 -> 100-cycle beep toggling every cycle; rst_n low mid-ON -> all outputs at reset values immediately.
REQ-041 With BUZZER_GAIN_SEL_EN, gain_sel=0 at start -> amp_gain=0 while busy, 1 after done.
